// File: rtl/asap_prog_loader.sv
// Program loader: receives bytes over an asynchronous strobe/data handshake,
// writes them into a 2^ADDR_W-byte program memory, verifies an XOR checksum
// byte and releases the CPU core (cpu_run) or flags an error (load_err).
module asap_prog_loader #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load_req,
  input  logic              strobe_in,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              ack,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_CNT = FULL_CNT - 1'b1;

  state_t                 state, state_n;
  logic [7:0]             csum, csum_n;
  logic [ADDR_W:0]        cnt_n;
  logic [ADDR_W-1:0]      addr_n;
  logic [7:0]             wdata_n;
  logic                   we_n;
  logic                   ack_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   strobe_hist;
  logic                   armed;
  logic                   strobe_sync;
  logic                   byte_edge;

  assign strobe_sync = sync_q[SYNC_STAGES-1];
  // An edge only counts once a genuine low level has been seen after reset,
  // so a strobe already high at reset release is not taken as a new byte.
  assign byte_edge   = strobe_sync & ~strobe_hist & armed;

  // Strobe synchronizer and edge history; keeps sampling even when ena is low
  // so that edges arriving while disabled are consumed and dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      fill_q      <= '0;
      strobe_hist <= 1'b0;
      armed       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others, giving a true shift chain.
      sync_q      <= {sync_q[SYNC_STAGES-2:0], strobe_in};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      strobe_hist <= strobe_sync;
      armed       <= armed | (fill_q[SYNC_STAGES-1] & ~strobe_sync);
    end
  end

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n = state;
    cnt_n   = byte_cnt;
    csum_n  = csum;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    we_n    = 1'b0;
    ack_n   = ack;
    case (state)
      S_IDLE: begin
        if (load_req) begin
          state_n = S_LOAD;
          cnt_n   = '0;
          csum_n  = '0;
        end
      end
      S_LOAD: begin
        if (!load_req) begin
          state_n = (byte_cnt == '0) ? S_IDLE : S_ERROR;
        end else if (byte_edge) begin
          we_n    = 1'b1;
          addr_n  = byte_cnt[ADDR_W-1:0];
          wdata_n = data_in;
          cnt_n   = byte_cnt + 1'b1;
          csum_n  = csum ^ data_in;
          ack_n   = ~ack;
          if (byte_cnt == LAST_CNT) state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!load_req) begin
          state_n = (byte_cnt == '0) ? S_IDLE : S_ERROR;
        end else if (byte_edge) begin
          ack_n   = ~ack;
          state_n = (data_in == csum) ? S_RUN : S_ERROR;
        end
      end
      S_RUN: begin
        if (load_req) begin
          state_n = S_LOAD;
          cnt_n   = '0;
          csum_n  = '0;
        end
      end
      S_ERROR: begin
        if (!load_req) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; ena low freezes everything and
  // suppresses the write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      csum      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      ack       <= 1'b0;
      cpu_run   <= 1'b0;
      load_err  <= 1'b0;
    end else if (ena) begin
      state     <= state_n;
      byte_cnt  <= cnt_n;
      csum      <= csum_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_we    <= we_n;
      ack       <= ack_n;
      cpu_run   <= (state_n == S_RUN);
      load_err  <= (state_n == S_ERROR);
    end else begin
      mem_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_asap_prog_loader.sv
// Scoreboard bench for asap_prog_loader: stimulus pushes expected memory
// writes into a queue, a negedge monitor pops and compares on each mem_we.
module tb_asap_prog_loader;

  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic              load_req;
  logic              strobe_in;
  logic [7:0]        data_in;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              ack;
  logic              cpu_run;
  logic              load_err;
  logic [ADDR_W:0]   byte_cnt;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t               exp_q[$];
  logic [ADDR_W-1:0] exp_addr;
  logic              exp_ack;
  int                pass_cnt;
  int                total_cnt;

  asap_prog_loader #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load_req  (load_req),
    .strobe_in (strobe_in),
    .data_in   (data_in),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .ack       (ack),
    .cpu_run   (cpu_run),
    .load_err  (load_err),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (rst_n && mem_we) begin
      check("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", 32'(mem_wdata), 32'(w.data));
      end
    end
  end

  // Deliver one byte. accept: loader is expected to take it (ack toggles);
  // is_prog: it is a program byte, so a memory write is expected;
  // hold: extra cycles strobe stays high; drop: release load_req on accept.
  task automatic send_byte(input logic [7:0] d, input bit accept, input bit is_prog,
                           input int hold, input bit drop);
    int n;
    if (is_prog) begin
      exp_q.push_back(wr_t'{addr: exp_addr, data: d});
      exp_addr++;
    end
    data_in   = d;
    strobe_in = 1'b1;
    if (accept) begin
      n = 0;
      while (ack === exp_ack && n < 10) begin
        @(negedge clk);
        n++;
      end
      exp_ack = ~exp_ack;
      check("ack_on_accept", 32'(ack), 32'(exp_ack));
      if (drop) load_req = 1'b0;
    end
    tick(hold);
    strobe_in = 1'b0;
    tick(4);
    if (!accept) check("ack_no_toggle", 32'(ack), 32'(exp_ack));
  endtask

  task automatic start_load();
    load_req = 1'b1;
    exp_addr = '0;
    tick(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_we"},    32'(mem_we),    32'h0);
    check({tag, "_ack"},   32'(ack),       32'h0);
    check({tag, "_run"},   32'(cpu_run),   32'h0);
    check({tag, "_err"},   32'(load_err),  32'h0);
    check({tag, "_cnt"},   32'(byte_cnt),  32'h0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    exp_ack   = 1'b0;
    exp_addr  = '0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    load_req  = 1'b0;
    strobe_in = 1'b0;
    data_in   = 8'h00;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);

    // Good load: bytes 0x00..0x0F, checksum 0x00.
    start_load();
    check("load1_cnt0", 32'(byte_cnt), 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1'b1, 1, 1'b0);
    check("load1_cnt16", 32'(byte_cnt), 32'd16);
    check("load1_ack16", 32'(ack), 32'd0);
    send_byte(8'h00, 1'b1, 1'b0, 1, 1'b1);
    check("load1_run", 32'(cpu_run), 32'd1);
    check("load1_err", 32'(load_err), 32'd0);
    check("load1_ack17", 32'(ack), 32'd1);
    check("load1_cnt", 32'(byte_cnt), 32'd16);
    check("load1_addr_hold", 32'(mem_addr), 32'hF);
    check("load1_data_hold", 32'(mem_wdata), 32'h0F);

    // Reload from RUN: 16 x 0x11, checksum 0x00.
    start_load();
    check("reload_run_low", 32'(cpu_run), 32'd0);
    check("reload_cnt0", 32'(byte_cnt), 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'h11, 1'b1, 1'b1, 1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0, 1, 1'b1);
    check("reload_run", 32'(cpu_run), 32'd1);
    check("reload_ack", 32'(ack), 32'(exp_ack));

    // Bad checksum: 0x00..0x0F then 0xFF.
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1'b1, 1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0, 1, 1'b0);
    check("badsum_err", 32'(load_err), 32'd1);
    check("badsum_run", 32'(cpu_run), 32'd0);
    send_byte(8'h66, 1'b0, 1'b0, 2, 1'b0);
    load_req = 1'b0;
    tick(1);
    check("badsum_idle_err", 32'(load_err), 32'd0);
    check("badsum_idle_run", 32'(cpu_run), 32'd0);
    send_byte(8'h77, 1'b0, 1'b0, 2, 1'b0);

    // Long strobe gives one byte; abort after 5 bytes.
    start_load();
    send_byte(8'hA5, 1'b1, 1'b1, 10, 1'b0);
    check("long_cnt", 32'(byte_cnt), 32'd1);
    check("long_addr", 32'(mem_addr), 32'h0);
    check("long_data", 32'(mem_wdata), 32'hA5);
    for (int i = 1; i < 5; i++) send_byte(8'(i), 1'b1, 1'b1, 1, 1'b0);
    check("abort5_cnt", 32'(byte_cnt), 32'd5);
    load_req = 1'b0;
    tick(1);
    check("abort5_err", 32'(load_err), 32'd1);
    tick(1);
    check("abort5_idle_err", 32'(load_err), 32'd0);
    start_load();
    load_req = 1'b0;
    tick(2);
    check("abort0_err", 32'(load_err), 32'd0);
    check("abort0_run", 32'(cpu_run), 32'd0);
    check("abort0_cnt", 32'(byte_cnt), 32'd0);

    // Edge while disabled is discarded; loading resumes afterwards.
    start_load();
    ena = 1'b0;
    send_byte(8'hEE, 1'b0, 1'b0, 4, 1'b0);
    ena = 1'b1;
    tick(1);
    check("ena_cnt", 32'(byte_cnt), 32'd0);
    send_byte(8'h3C, 1'b1, 1'b1, 1, 1'b0);
    check("ena_resume_cnt", 32'(byte_cnt), 32'd1);

    // Reset after byte 7 clears outputs at once; next strobe writes nothing.
    for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i), 1'b1, 1'b1, 1, 1'b0);
    check("pre_rst_cnt", 32'(byte_cnt), 32'd7);
    #2;
    rst_n    = 1'b0;
    load_req = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    send_byte(8'h99, 1'b0, 1'b0, 2, 1'b0);
    check("post_rst_cnt", 32'(byte_cnt), 32'd0);

    // Strobe already high at reset release must not count as a byte.
    strobe_in = 1'b1;
    data_in   = 8'hC3;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    load_req = 1'b1;
    exp_addr = '0;
    tick(8);
    check("hi_rel_ack", 32'(ack), 32'(exp_ack));
    check("hi_rel_cnt", 32'(byte_cnt), 32'd0);
    strobe_in = 1'b0;
    tick(4);
    send_byte(8'h5A, 1'b1, 1'b1, 1, 1'b0);
    check("hi_rel_next_cnt", 32'(byte_cnt), 32'd1);
    check("hi_rel_next_data", 32'(mem_wdata), 32'h5A);

    tick(2);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/asap_prog_loader.md
ASAP_PROG_LOADER -- requirements
Module: asap_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, program-memory address width (depth 2^ADDR_W bytes).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops on strobe_in (min 2).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ena  in  1  design-selected enable; low freezes all state.
REQ-006 load_req  in  1  host level request to (re)load program; synchronous to clk.
REQ-007 strobe_in  in  1  asynchronous host byte strobe; each rising edge delivers one byte.
REQ-008 data_in  in  8  host byte; held stable by host while strobe_in high.
REQ-009 mem_addr  out  ADDR_W  program-memory write address.
REQ-010 mem_wdata  out  8  program-memory write data.
REQ-011 mem_we  out  1  program-memory write enable, one-cycle pulse.
REQ-012 ack  out  1  toggles once per accepted byte (program or checksum).
REQ-013 cpu_run  out  1  releases downstream CPU core; high only in RUN.
REQ-014 load_err  out  1  high only in ERROR.
REQ-015 byte_cnt  out  ADDR_W+1  program bytes written in current load.

Function
REQ-016 strobe_in SHALL pass through SYNC_STAGES flops plus one edge-history flop; a byte SHALL be accepted only on a synchronized 0->1 transition.
REQ-017 With SYNC_STAGES=2, mem_we SHALL rise right after the 3rd rising clk edge at which strobe_in is sampled high; data_in SHALL be captured in the same cycle as the edge detection.
REQ-018 Strobe held high any number of cycles SHALL yield exactly one accepted byte.
REQ-019 States: IDLE, LOAD, CHECK, RUN, ERROR; encoding is implementer's choice.
REQ-020 IDLE: on ena && load_req -> LOAD; clear address, byte_cnt, checksum (8-bit XOR accumulator) to 0.
REQ-021 LOAD: each accepted byte -> mem_we=1 for one cycle with mem_addr=current address, mem_wdata=byte; address+1, byte_cnt+1, checksum^=byte, ack toggles.
REQ-022 LOAD: acceptance of byte 2^ADDR_W -> CHECK; address wraps to 0, byte_cnt holds 2^ADDR_W.
REQ-023 CHECK: next accepted byte compared to checksum, no mem_we; equal -> RUN, else -> ERROR; ack toggles either way.
REQ-024 LOAD or CHECK with load_req low: byte_cnt==0 -> IDLE; else -> ERROR; a strobe edge in the same cycle is discarded.
REQ-025 RUN: cpu_run=1; load_req high -> LOAD (clears as in REQ-020); cpu_run low the cycle after.
REQ-026 ERROR: load_err=1, cpu_run=0, strobes ignored; load_req low -> IDLE.
REQ-027 Strobe edges in IDLE, RUN, ERROR SHALL be discarded (no mem_we, no ack toggle).
REQ-028 ena low: state, counters, outputs held; mem_we forced 0; edges detected while ena low SHALL be discarded, synchronizer keeps sampling.
REQ-029 All outputs SHALL be registered; mem_addr/mem_wdata hold last written values between pulses.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, mem_addr=0, mem_wdata=0x00, mem_we=0, ack=0, cpu_run=0, load_err=0, byte_cnt=0, checksum=0, synchronizer and edge flops=0.
REQ-031 Reset mid-LOAD SHALL abort with no further mem_we; partial memory contents are not cleared.
REQ-032 Release of rst_n with strobe_in already high SHALL NOT produce an accepted byte until strobe_in falls and rises again.

Verification
REQ-033 load_req=1, bytes 0x00..0x0F, checksum 0x00 -> 16 mem_we pulses at addr 0..15 with data=addr, byte_cnt=16, ack toggled 17 times (ends 1), cpu_run=1.
REQ-034 Same 16 bytes, checksum 0xFF -> load_err=1, cpu_run=0; load_req low -> IDLE, load_err=0.
REQ-035 Strobe held high 10 cycles with data 0xA5 in LOAD -> exactly one mem_we, addr 0, data 0xA5, byte_cnt=1.
REQ-036 load_req dropped after 5 bytes -> ERROR, load_err=1; dropped after 0 bytes -> IDLE, load_err=0.
REQ-037 rst_n pulsed low after byte 7 -> all outputs at reset values within same cycle, next strobe produces no mem_we.
REQ-038 From RUN, load_req re-asserted, bytes 0x11 x16 plus checksum 0x00 -> cpu_run low during reload, addr restarts at 0, RUN re-entered.
